// File: rtl/counter_updn_mod.sv
// counter_updn_mod: parametrised up/down counter over 0..MAX.
// Supports count enable, synchronous load with clamp to MAX, and either
// wrap or saturate at the count boundaries. A sticky ovf flag records
// every enabled step taken at a boundary. rco flags the terminal count.
module counter_updn_mod #(
  parameter int N   = 4,
  parameter int MAX = 2**N-1
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  input  logic         up,
  input  logic         ld,
  input  logic [N-1:0] din,
  input  logic         sat,
  input  logic         ovf_clr,
  output logic [N-1:0] cnt,
  output logic         rco,
  output logic         ovf
);

  localparam logic [N-1:0] MAXV = N'(MAX);
  localparam logic [N-1:0] ZERO = '0;
  localparam logic [N-1:0] ONE  = N'(1);

  // Load values above the terminal count are pulled back to MAX so the
  // counter never enters the unreachable region above MAX.
  function automatic logic [N-1:0] clamp_load(input logic [N-1:0] v);
    return (v > MAXV) ? MAXV : v;
  endfunction

  // Step taken from the top boundary: back to zero when wrapping,
  // stay at MAX when saturating.
  function automatic logic [N-1:0] top_step(input logic s);
    return s ? MAXV : ZERO;
  endfunction

  // Step taken from the bottom boundary: round to MAX when wrapping,
  // stay at zero when saturating.
  function automatic logic [N-1:0] bot_step(input logic s);
    return s ? ZERO : MAXV;
  endfunction

  logic         at_top;
  logic         at_bot;
  logic         at_bnd;
  logic         bnd_step;
  logic [N-1:0] cnt_nxt;

  assign at_top   = (cnt == MAXV);
  assign at_bot   = (cnt == ZERO);
  assign at_bnd   = up ? at_top : at_bot;

  // A load takes priority over counting, so it can never raise ovf.
  assign bnd_step = en & ~ld & at_bnd;

  // Terminal count indication, high in the cycle before a wrap/saturate.
  assign rco      = en & at_bnd;

  // Next-count selection: ld > en > hold.
  always_comb begin
    cnt_nxt = cnt;
    if (ld) begin
      cnt_nxt = clamp_load(din);
    end else if (en) begin
      if (up) begin
        cnt_nxt = at_top ? top_step(sat) : (cnt + ONE);
      end else begin
        cnt_nxt = at_bot ? bot_step(sat) : (cnt - ONE);
      end
    end
  end

  // Count register; clr drops the count to zero immediately.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt <= ZERO;
    end else begin
      cnt <= cnt_nxt;
    end
  end

  // Sticky boundary flag; a set event outranks ovf_clr in the same cycle.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      ovf <= 1'b0;
    end else if (bnd_step) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_counter_updn_mod.sv
// Directed bench for counter_updn_mod: one instance with MAX=15 (full
// range) and one with MAX=9 (partial range), sharing a clock.
module tb_counter_updn_mod;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: N=4, MAX=15
  logic       a_clr, a_en, a_up, a_ld, a_sat, a_ovf_clr;
  logic [3:0] a_din, a_cnt;
  logic       a_rco, a_ovf;

  // Instance B: N=4, MAX=9
  logic       b_clr, b_en, b_up, b_ld, b_sat, b_ovf_clr;
  logic [3:0] b_din, b_cnt;
  logic       b_rco, b_ovf;

  int checks = 0;
  int errors = 0;

  counter_updn_mod #(.N(4), .MAX(15)) u_a (
    .clk(clk), .clr(a_clr), .en(a_en), .up(a_up), .ld(a_ld), .din(a_din),
    .sat(a_sat), .ovf_clr(a_ovf_clr), .cnt(a_cnt), .rco(a_rco), .ovf(a_ovf)
  );

  counter_updn_mod #(.N(4), .MAX(9)) u_b (
    .clk(clk), .clr(b_clr), .en(b_en), .up(b_up), .ld(b_ld), .din(b_din),
    .sat(b_sat), .ovf_clr(b_ovf_clr), .cnt(b_cnt), .rco(b_rco), .ovf(b_ovf)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    a_clr = 1'b1; a_en = 1'b1; a_up = 1'b1; a_ld = 1'b0; a_sat = 1'b0;
    a_ovf_clr = 1'b0; a_din = 4'd0;
    b_clr = 1'b1; b_en = 1'b1; b_up = 1'b0; b_ld = 1'b0; b_sat = 1'b0;
    b_ovf_clr = 1'b0; b_din = 4'd0;
    #1;
    // reset state; rco during clr equals en & ~up
    chk("a_rst_cnt", 8'(a_cnt), 8'd0);
    chk("a_rst_ovf", 8'(a_ovf), 8'd0);
    chk("a_rst_rco", 8'(a_rco), 8'd0);
    chk("b_rst_rco", 8'(b_rco), 8'd1);
    tick();
    chk("b_rst_hold_cnt", 8'(b_cnt), 8'd0);

    // A: wrap-up over full range, 18 clocks
    a_clr = 1'b0;
    for (int i = 1; i <= 18; i++) begin
      tick();
      chk("a_up_cnt", 8'(a_cnt), 8'(i % 16));
      chk("a_up_rco", 8'(a_rco), 8'((i % 16) == 15));
      chk("a_up_ovf", 8'(a_ovf), 8'(i >= 16));
    end
    a_en = 1'b0;
    chk("a_hold_rco", 8'(a_rco), 8'd0);

    // B: wrap-down from 0 with MAX=9: 9,8,...,0,9
    b_clr = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      tick();
      chk("b_dn_cnt", 8'(b_cnt), 8'((20 - i) % 10));
      chk("b_dn_rco", 8'(b_rco), 8'(((20 - i) % 10) == 0));
      chk("b_dn_ovf", 8'(b_ovf), 8'd1);
    end

    // B: ovf_clr alone, counting disabled
    b_en = 1'b0; b_ovf_clr = 1'b1;
    tick();
    chk("b_ovfclr_ovf", 8'(b_ovf), 8'd0);
    chk("b_ovfclr_cnt", 8'(b_cnt), 8'd9);
    b_ovf_clr = 1'b0;

    // B: saturate up from load of 7
    b_sat = 1'b1; b_up = 1'b1; b_ld = 1'b1; b_din = 4'd7;
    tick();
    chk("b_sup_ld_cnt", 8'(b_cnt), 8'd7);
    chk("b_sup_ld_ovf", 8'(b_ovf), 8'd0);
    b_ld = 1'b0; b_en = 1'b1;
    tick(); chk("b_sup_cnt1", 8'(b_cnt), 8'd8); chk("b_sup_ovf1", 8'(b_ovf), 8'd0);
    tick(); chk("b_sup_cnt2", 8'(b_cnt), 8'd9); chk("b_sup_ovf2", 8'(b_ovf), 8'd0);
    chk("b_sup_rco2", 8'(b_rco), 8'd1);
    tick(); chk("b_sup_cnt3", 8'(b_cnt), 8'd9); chk("b_sup_ovf3", 8'(b_ovf), 8'd1);
    tick(); chk("b_sup_cnt4", 8'(b_cnt), 8'd9); chk("b_sup_ovf4", 8'(b_ovf), 8'd1);
    b_en = 1'b0;
    #1;
    chk("b_en0_rco", 8'(b_rco), 8'd0);
    tick();
    chk("b_en0_cnt", 8'(b_cnt), 8'd9);

    // B: ovf_clr alone again, then saturate down from load of 1
    b_ovf_clr = 1'b1;
    tick();
    chk("b_ovfclr2_ovf", 8'(b_ovf), 8'd0);
    b_ovf_clr = 1'b0; b_up = 1'b0; b_ld = 1'b1; b_din = 4'd1;
    tick();
    chk("b_sdn_ld_cnt", 8'(b_cnt), 8'd1);
    b_ld = 1'b0; b_en = 1'b1;
    tick(); chk("b_sdn_cnt1", 8'(b_cnt), 8'd0); chk("b_sdn_ovf1", 8'(b_ovf), 8'd0);
    tick(); chk("b_sdn_cnt2", 8'(b_cnt), 8'd0); chk("b_sdn_ovf2", 8'(b_ovf), 8'd1);
    tick(); chk("b_sdn_cnt3", 8'(b_cnt), 8'd0);

    // B: load priority over en, clamp above MAX, ovf untouched
    b_up = 1'b1; b_ld = 1'b1; b_din = 4'd12;
    tick();
    chk("b_clamp_cnt", 8'(b_cnt), 8'd9);
    chk("b_clamp_ovf", 8'(b_ovf), 8'd1);
    b_din = 4'd3;
    tick();
    chk("b_ld3_cnt", 8'(b_cnt), 8'd3);
    chk("b_ld3_ovf", 8'(b_ovf), 8'd1);

    // B: ovf_clr concurrent with wrap: set wins
    b_en = 1'b0; b_sat = 1'b0; b_din = 4'd9; b_ovf_clr = 1'b1;
    tick();
    chk("b_pre_cnt", 8'(b_cnt), 8'd9);
    chk("b_pre_ovf", 8'(b_ovf), 8'd0);
    b_ld = 1'b0; b_en = 1'b1;
    tick();
    chk("b_setwin_cnt", 8'(b_cnt), 8'd0);
    chk("b_setwin_ovf", 8'(b_ovf), 8'd1);
    b_ovf_clr = 1'b0; b_en = 1'b0;

    // A: async clr mid-count at 6 (ovf is still 1 from the wrap)
    a_ld = 1'b1; a_din = 4'd5;
    tick();
    chk("a_ld5_cnt", 8'(a_cnt), 8'd5);
    a_ld = 1'b0; a_en = 1'b1;
    tick();
    chk("a_six_cnt", 8'(a_cnt), 8'd6);
    chk("a_six_ovf", 8'(a_ovf), 8'd1);
    #2;
    a_clr = 1'b1;
    #1;
    chk("a_aclr_cnt", 8'(a_cnt), 8'd0);
    chk("a_aclr_ovf", 8'(a_ovf), 8'd0);
    tick();
    chk("a_aclr_hold", 8'(a_cnt), 8'd0);
    a_clr = 1'b0;
    tick();
    chk("a_resume_cnt", 8'(a_cnt), 8'd1);
    tick();
    chk("a_resume_cnt2", 8'(a_cnt), 8'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
